// File: rtl/switch_pkg.sv
// ----------------------------------------------------------------------------
// switch_pkg
// Shared definitions for the shared-memory switch fabric egress side.
//   - Default fabric dimensions: PORT_NUB, DATA_WIDTH, PKT_LEN, WIDTH_SEL.
//   - lane_state_t: per-output read lane FSM states (IDLE, READ).
//   - fifo_entry_t: one egress FIFO entry {src, sop, eop, data} at the
//     default dimensions.
// ----------------------------------------------------------------------------
package switch_pkg;

    localparam int PORT_NUB   = 8;
    localparam int DATA_WIDTH = 32;
    localparam int PKT_LEN    = 16;
    localparam int WIDTH_SEL  = $clog2(PORT_NUB);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } lane_state_t;

    typedef struct packed {
        logic [WIDTH_SEL-1:0]  src;
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/egress_lane.sv
// ----------------------------------------------------------------------------
// egress_lane
// One output lane of the egress read scheduler: picks a source packet,
// reads it word by word out of the fabric and re-times the returned words
// onto a valid/ready stream through a 2-entry FIFO.
//
// Configuration macro: EGRESS_READ_SCHEDULER_STRICT_PRIO_EN
//   defined   -> lowest-index non-empty source always wins, ptr stays 0
//   undefined -> round-robin starting at ptr
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   empty         per-source "no complete packet" flags for this output
//   data_in       fabric read data, valid 1 cycle after rd_en
//   rd_sel        source select into the fabric (held in IDLE)
//   rd_en         word read strobe
//   rd_done       1-cycle pulse with the last word's rd_en
//   tx_valid/ready egress handshake
//   tx_data/sop/eop/src egress word and its tags
// ----------------------------------------------------------------------------
module egress_lane #(
    parameter int PORT_NUB   = switch_pkg::PORT_NUB,
    parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
    parameter int PKT_LEN    = switch_pkg::PKT_LEN,
    parameter int WIDTH_SEL  = switch_pkg::WIDTH_SEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PORT_NUB-1:0]   empty,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [WIDTH_SEL-1:0]  rd_sel,
    output logic                  rd_en,
    output logic                  rd_done,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic [WIDTH_SEL-1:0]  tx_src
);
    import switch_pkg::*;

    localparam int WCNT_W = $clog2(PKT_LEN + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(PKT_LEN - 1);

    typedef struct packed {
        logic [WIDTH_SEL-1:0]  src;
        logic                  sop;
        logic                  eop;
        logic [DATA_WIDTH-1:0] data;
    } lane_entry_t;

    lane_state_t          state, state_nxt;
    logic [WIDTH_SEL-1:0] ptr, gnt, pick, idx;
    logic                 found;
    logic [WCNT_W-1:0]    wcnt;
    logic                 last_word;
    logic                 inflight;
    logic [WIDTH_SEL-1:0] tag_src;
    logic                 tag_sop, tag_eop;
    lane_entry_t          fifo_mem [2];
    logic                 wr_idx, rd_idx;
    logic [1:0]           fifo_cnt;
    logic [1:0]           credit_used;
    logic                 push, pop;
    logic [PORT_NUB-1:0]  req;

    assign req         = ~empty;
    assign last_word   = (wcnt == LAST_WORD);
    assign credit_used = fifo_cnt + {1'b0, inflight};
    assign push        = inflight;
    assign pop         = tx_valid && tx_ready;

    // Arbiter: first requesting source at or after ptr, wrapping at the top.
    // PORT_NUB is a power of two so the index addition wraps by itself. In the
    // strict-priority build ptr never moves off 0, which makes this search a
    // plain lowest-index pick.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < PORT_NUB; k++) begin
            idx = ptr + WIDTH_SEL'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next-state and strobes. A read is issued only while the FIFO plus the
    // word still in flight from the fabric leave room, so two entries suffice.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_nxt = READ;
            end
            READ: begin
                rd_en = (credit_used < 2'd2);
                if (rd_en && last_word) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, grant, round-robin pointer and word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            gnt   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && found) begin
                gnt  <= pick;
                wcnt <= '0;
`ifndef EGRESS_READ_SCHEDULER_STRICT_PRIO_EN
                ptr  <= pick + WIDTH_SEL'(1);
`endif
            end else if (rd_en) begin
                wcnt <= wcnt + WCNT_W'(1);
            end
        end
    end

    // Word tags travel one cycle behind rd_en so they line up with data_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            tag_src  <= '0;
            tag_sop  <= 1'b0;
            tag_eop  <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                tag_src <= gnt;
                tag_sop <= (wcnt == '0);
                tag_eop <= last_word;
            end
        end
    end

    // 2-entry egress FIFO; entries are cleared on reset so the outputs read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx      <= 1'b0;
            rd_idx      <= 1'b0;
            fifo_cnt    <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_idx] <= '{src: tag_src, sop: tag_sop,
                                      eop: tag_eop, data: data_in};
                wr_idx <= ~wr_idx;
            end
            if (pop) rd_idx <= ~rd_idx;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign rd_sel   = gnt;
    assign tx_valid = (fifo_cnt != 2'd0);
    assign tx_data  = fifo_mem[rd_idx].data;
    assign tx_sop   = fifo_mem[rd_idx].sop;
    assign tx_eop   = fifo_mem[rd_idx].eop;
    assign tx_src   = fifo_mem[rd_idx].src;

endmodule

// File: rtl/egress_read_scheduler.sv
// ----------------------------------------------------------------------------
// egress_read_scheduler
// Per-output read scheduler for the shared-memory switch fabric. Slices the
// fabric and egress buses and instantiates one egress_lane per output port.
//
// Configuration macro: EGRESS_READ_SCHEDULER_STRICT_PRIO_EN (see egress_lane)
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   empty_in   [i*PORT_NUB +: PORT_NUB] empty flags of output i, bit j = src j
//   data_in    fabric read data, one DATA_WIDTH slice per output
//   rd_sel     per-output source select (WIDTH_SEL slices)
//   rd_en      per-output word read strobe
//   rd_done    per-output end-of-packet read pulse
//   tx_*       per-output valid/ready egress stream with sop/eop/src tags
// ----------------------------------------------------------------------------
module egress_read_scheduler #(
    parameter int PORT_NUB   = switch_pkg::PORT_NUB,
    parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
    parameter int PKT_LEN    = switch_pkg::PKT_LEN,
    parameter int WIDTH_SEL  = switch_pkg::WIDTH_SEL
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUB*PORT_NUB-1:0]   empty_in,
    input  logic [PORT_NUB*DATA_WIDTH-1:0] data_in,
    output logic [PORT_NUB*WIDTH_SEL-1:0]  rd_sel,
    output logic [PORT_NUB-1:0]            rd_en,
    output logic [PORT_NUB-1:0]            rd_done,
    output logic [PORT_NUB-1:0]            tx_valid,
    input  logic [PORT_NUB-1:0]            tx_ready,
    output logic [PORT_NUB*DATA_WIDTH-1:0] tx_data,
    output logic [PORT_NUB-1:0]            tx_sop,
    output logic [PORT_NUB-1:0]            tx_eop,
    output logic [PORT_NUB*WIDTH_SEL-1:0]  tx_src
);
    import switch_pkg::*;

    // Lanes are fully independent; each sees only its own bus slices.
    for (genvar i = 0; i < PORT_NUB; i++) begin : g_lane
        egress_lane #(
            .PORT_NUB   (PORT_NUB),
            .DATA_WIDTH (DATA_WIDTH),
            .PKT_LEN    (PKT_LEN),
            .WIDTH_SEL  (WIDTH_SEL)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .empty    (empty_in[i*PORT_NUB +: PORT_NUB]),
            .data_in  (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_sel   (rd_sel[i*WIDTH_SEL +: WIDTH_SEL]),
            .rd_en    (rd_en[i]),
            .rd_done  (rd_done[i]),
            .tx_valid (tx_valid[i]),
            .tx_ready (tx_ready[i]),
            .tx_data  (tx_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .tx_sop   (tx_sop[i]),
            .tx_eop   (tx_eop[i]),
            .tx_src   (tx_src[i*WIDTH_SEL +: WIDTH_SEL])
        );
    end

endmodule

// File: tb/tb_egress_read_scheduler.sv
// ----------------------------------------------------------------------------
// tb_egress_read_scheduler
// Scoreboard bench for egress_read_scheduler. A fabric model holds per
// (output, source) packet counts and answers reads; a packet-level reference
// model predicts, per lane, the ordered list of egress words whenever counts
// are loaded. A monitor compares every presented egress word to the head of
// its lane's queue.
// ----------------------------------------------------------------------------
module tb_egress_read_scheduler;
    import switch_pkg::*;

    localparam int N  = PORT_NUB;
    localparam int DW = DATA_WIDTH;
    localparam int WS = WIDTH_SEL;

    logic              clk;
    logic              rst;
    logic [N*N-1:0]    empty_in;
    logic [N*DW-1:0]   data_in;
    logic [N*WS-1:0]   rd_sel;
    logic [N-1:0]      rd_en;
    logic [N-1:0]      rd_done;
    logic [N-1:0]      tx_valid;
    logic [N-1:0]      tx_ready;
    logic [N*DW-1:0]   tx_data;
    logic [N-1:0]      tx_sop;
    logic [N-1:0]      tx_eop;
    logic [N*WS-1:0]   tx_src;

    egress_read_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .empty_in (empty_in),
        .data_in  (data_in),
        .rd_sel   (rd_sel),
        .rd_en    (rd_en),
        .rd_done  (rd_done),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_src   (tx_src)
    );

    typedef struct {
        int            src;
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } exp_t;

    exp_t expq [N][$];

    int fab_cnt  [N][N];
    int fab_ser  [N][N];
    int fab_widx [N][N];
    int load_val [N][N];
    int plan_cnt [N][N];
    int model_ptr [N];
    int load_seq;
    int load_seen;

    int n_vec;
    int n_err;
    int pops0;

    logic         rand_bp;
    logic [N-1:0] ready_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_val(int lane, int src, int ser, int w);
        logic [31:0] v;
        v = {8'(lane), 8'(src), 8'(ser), 8'(w)} ^ 32'hA5C3_0000;
        return DW'(v);
    endfunction

    function automatic int sel_of(int lane);
        return int'(rd_sel[lane*WS +: WS]);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Fabric: packet counters, read data 1 cycle after rd_en, decrement on rd_done.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rd_en[i]) begin
                data_in[i*DW +: DW] <= word_val(i, sel_of(i), fab_ser[i][sel_of(i)],
                                                fab_widx[i][sel_of(i)]);
                fab_widx[i][sel_of(i)] <= fab_widx[i][sel_of(i)] + 1;
            end else begin
                data_in[i*DW +: DW] <= DW'($urandom);
            end
            if (rd_done[i]) begin
                fab_widx[i][sel_of(i)] <= 0;
                fab_ser[i][sel_of(i)]  <= fab_ser[i][sel_of(i)] + 1;
                fab_cnt[i][sel_of(i)]  <= fab_cnt[i][sel_of(i)] - 1;
            end
        end
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    fab_widx[i][j] <= 0;
        end
        if (load_seq != load_seen) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    fab_cnt[i][j] <= load_val[i][j];
            load_seen <= load_seq;
        end
    end

    always_comb begin
        empty_in = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                empty_in[i*N + j] = (fab_cnt[i][j] == 0);
    end

    // Egress ready: either a forced pattern or random backpressure per cycle.
    initial begin
        tx_ready = '1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) tx_ready = N'($urandom);
            else         tx_ready = ready_force;
        end
    end

    // Reference model: drain plan_cnt for a lane packet by packet.
    task automatic planLane(input int lane);
        int c [N];
        int serk [N];
        int s;
        for (int j = 0; j < N; j++) begin
            c[j]    = plan_cnt[lane][j];
            serk[j] = fab_ser[lane][j];
        end
        while (1) begin
            s = -1;
            for (int k = 0; k < N; k++) begin
`ifdef EGRESS_READ_SCHEDULER_STRICT_PRIO_EN
                if (s < 0 && c[k] > 0) s = k;
`else
                if (s < 0 && c[(model_ptr[lane] + k) % N] > 0) s = (model_ptr[lane] + k) % N;
`endif
            end
            if (s < 0) break;
            for (int w = 0; w < PKT_LEN; w++) begin
                exp_t e;
                e.src  = s;
                e.sop  = (w == 0);
                e.eop  = (w == PKT_LEN - 1);
                e.data = word_val(lane, s, serk[s], w);
                expq[lane].push_back(e);
            end
            c[s]--;
            serk[s]++;
`ifndef EGRESS_READ_SCHEDULER_STRICT_PRIO_EN
            model_ptr[lane] = (s + 1) % N;
`endif
        end
    endtask

    // Load load_val into the fabric and predict the resulting egress words.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) plan_cnt[i][j] = load_val[i][j];
            planLane(i);
        end
        load_seq++;
    endtask

    task automatic clearLoad();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                load_val[i][j] = 0;
    endtask

    task automatic waitDrain(input int budget);
        int left;
        int quiet;
        left  = 0;
        quiet = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            left = 0;
            for (int i = 0; i < N; i++) left += expq[i].size();
            if (left == 0 && tx_valid == '0) quiet++;
            else quiet = 0;
            if (quiet >= 4) break;
        end
        checkOutput("drain_words_left", 64'(left), 64'd0);
    endtask

    // Monitor: compare every presented word to the scoreboard head.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (tx_valid[i]) begin
                        if (expq[i].size() == 0) begin
                            checkOutput("unexpected_word", 64'(tx_valid[i]), 64'd0);
                        end else begin
                            mon_e = expq[i][0];
                            checkOutput("tx_data", 64'(tx_data[i*DW +: DW]), 64'(mon_e.data));
                            checkOutput("tx_src",  64'(tx_src[i*WS +: WS]),  64'(mon_e.src));
                            checkOutput("tx_sop",  64'(tx_sop[i]),           64'(mon_e.sop));
                            checkOutput("tx_eop",  64'(tx_eop[i]),           64'(mon_e.eop));
                            if (tx_ready[i]) begin
                                void'(expq[i].pop_front());
                                if (i == 0) pops0++;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        n_vec = 0; n_err = 0; pops0 = 0;
        load_seq = 0; load_seen = 0;
        rand_bp = 1'b0;
        ready_force = '1;
        data_in = '0;
        for (int i = 0; i < N; i++) begin
            model_ptr[i] = 0;
            for (int j = 0; j < N; j++) begin
                fab_cnt[i][j] = 0; fab_ser[i][j] = 0; fab_widx[i][j] = 0;
            end
        end
        rst = 1'b1;

        // Reset with every source holding one packet on every output.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                load_val[i][j] = 1;
        applyStimulus();
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_rd_en",    64'(rd_en),    64'd0);
            checkOutput("reset_rd_done",  64'(rd_done),  64'd0);
            checkOutput("reset_rd_sel",   64'(rd_sel),   64'd0);
            checkOutput("reset_tx_valid", 64'(tx_valid), 64'd0);
            checkOutput("reset_tx_flags", 64'({tx_sop, tx_eop}), 64'd0);
            checkOutput("reset_tx_src",   64'(tx_src),   64'd0);
            checkOutput("reset_tx_data",  64'(tx_data),  64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_rd_en_lane0", 64'(rd_en[0]), 64'd1);
        waitDrain(4000);
        $display("[TB] reset / all-sources drain done");

        // Round-robin over sources 1, 3, 6 on lane 0.
        clearLoad();
        load_val[0][1] = 2; load_val[0][3] = 2; load_val[0][6] = 2;
        applyStimulus();
        waitDrain(4000);

        // Backpressure mid-packet on lane 0.
        clearLoad();
        load_val[0][2] = 1; load_val[0][5] = 1;
        pops0 = 0;
        applyStimulus();
        for (int c = 0; c < 500 && pops0 < 5; c++) @(negedge clk);
        checkOutput("bp_reached_mid_packet", 64'(pops0 >= 5), 64'd1);
        ready_force[0] = 1'b0;
        @(negedge clk);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_en[0]) cnt++;
        end
        checkOutput("bp_rd_en_at_most_2", 64'(cnt > 2), 64'd0);
        ready_force[0] = 1'b1;
        waitDrain(4000);

        // Wrap: source 6 moves ptr to 7, then source 7 twice wraps ptr to 0.
        clearLoad();
        load_val[0][6] = 1;
        applyStimulus();
        waitDrain(4000);
        clearLoad();
        load_val[0][7] = 2;
        applyStimulus();
        waitDrain(4000);

        // Randomised counts on all lanes with random backpressure.
        for (int r = 0; r < 6; r++) begin
            clearLoad();
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    load_val[i][j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            rand_bp = 1'b1;
            applyStimulus();
            waitDrain(8000);
            rand_bp = 1'b0;
        end
        $display("[TB] random rounds done");

        // Reset while lane 0 is reading word 5 of a packet.
        clearLoad();
        load_val[0][3] = 1; load_val[0][4] = 1;
        applyStimulus();
        cnt = 0;
        for (int c = 0; c < 500 && cnt < 6; c++) begin
            @(negedge clk);
            if (rd_en[0]) cnt++;
        end
        checkOutput("mid_reset_reached_word5", 64'(cnt), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_tx_valid", 64'(tx_valid), 64'd0);
        checkOutput("mid_reset_rd_done",  64'(rd_done),  64'd0);
        @(negedge clk);
        checkOutput("mid_reset_rd_done2", 64'(rd_done),  64'd0);
        for (int i = 0; i < N; i++) begin
            expq[i].delete();
            model_ptr[i] = 0;
            for (int j = 0; j < N; j++) plan_cnt[i][j] = fab_cnt[i][j];
            planLane(i);
        end
        rst = 1'b0;
        waitDrain(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
